dmem_wait_responder: RTL

// - Data-memory responder for the pipelined MIPS MEM stage. The MEM stage is the initiator; this block is the target.
// - Accepts one word load/store request at a time and completes it after a programmable number of wait states.
// - Drives the stall request that the hazard logic uses to freeze IF/ID/EX/MEM.
// - Returns read data with a one-cycle response strobe. Replaces the zero-latency behavioural data memory.

---
 rtl/dmem_wait_responder_if.sv | 21 ++
 rtl/dmem_wait_responder.sv | 106 ++++++++++
 2 files changed

// File: rtl/dmem_wait_responder_if.sv
// Handshake bundle between the MIPS MEM stage (master) and the wait-state data memory (slave).
interface dmem_wait_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  stall, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output stall, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_wait_responder.sv
// Word-wide data memory for the MEM stage that answers each access after WAIT_CYCLES wait states
// and freezes the pipeline through stall until the response cycle.
module dmem_wait_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input logic                clk,
  input logic                reset,
  dmem_wait_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH] = '{default: '0};

  logic                  acc_go;
  logic                  acc_we;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic                  acc_err;
  logic [DEPTH_LOG2-1:0] acc_idx;

  // With zero wait states the access happens on the accepting edge, so use the live request.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_go    = 1'b0;
    if (state == IDLE) begin
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_go    = bus.req_valid && (WAIT_CYCLES == 0);
    end else if (state == WAIT) begin
      acc_go = (cnt == 4'd1);
    end
  end

  assign acc_idx = acc_addr[DEPTH_LOG2+1:2];
  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:DEPTH_LOG2+2] != '0);

  assign bus.stall = !reset && ((state == IDLE && bus.req_valid) || state == WAIT);

  always_ff @(posedge clk) begin
    if (!reset && acc_go && acc_we && !acc_err) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
      if (acc_go) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= acc_err;
        if (!acc_err && !acc_we) begin
          bus.rsp_rdata <= mem[acc_idx];
        end
      end

      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
          end
        end
        // The requesting instruction leaves MEM this cycle, so req_valid is not looked at.
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
